// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one scratch-memory port between DMA, CPU and ACL.
// Read data is steered back to its requester by a tag pipe matching memory latency.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_lock,
  input  logic                  dma_en,
  input  logic                  cpu_en,
  input  logic                  acl_en,
  input  logic                  dma_wr_en,
  input  logic                  cpu_wr_en,
  input  logic                  acl_wr_en,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [ADDR_WIDTH-1:0] acl_addr,
  input  logic [DATA_WIDTH-1:0] dma_data,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic [DATA_WIDTH-1:0] acl_data,
  output logic                  dma_gnt,
  output logic                  cpu_gnt,
  output logic                  acl_gnt,
  output logic [DATA_WIDTH-1:0] dma_out,
  output logic [DATA_WIDTH-1:0] cpu_out,
  output logic [DATA_WIDTH-1:0] acl_out,
  output logic                  dma_valid,
  output logic                  cpu_valid,
  output logic                  acl_valid,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [1:0] ptr;
  logic [1:0] p;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gid;
  logic [1:0] idx;
  logic       hit;
  logic       fire;

  assign p = (ptr == 2'd3) ? 2'd0 : ptr;

  always_comb begin
    req = dma_lock ? {2'b00, dma_en}
                   : {acl_en, cpu_en, dma_en};
  end

  always_comb begin
    hit = 1'b0;
    gid = 2'd0;
    idx = p;
    for (int k = 0; k < 3; k++) begin
      if (!hit && req[idx]) begin
        hit = 1'b1;
        gid = idx;
      end
      idx = inc3(idx);
    end
  end

  assign fire = hit && !rst;

  always_comb begin
    gnt = 3'b000;
    if (fire) gnt[gid] = 1'b1;
  end

  assign dma_gnt = gnt[0];
  assign cpu_gnt = gnt[1];
  assign acl_gnt = gnt[2];

  always_comb begin
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    unique case (1'b1)
      gnt[0]: begin
        mem_en    = 1'b1;
        mem_wr_en = dma_wr_en;
        mem_addr  = dma_addr;
        mem_data  = dma_data;
      end
      gnt[1]: begin
        mem_en    = 1'b1;
        mem_wr_en = cpu_wr_en;
        mem_addr  = cpu_addr;
        mem_data  = cpu_data;
      end
      gnt[2]: begin
        mem_en    = 1'b1;
        mem_wr_en = acl_wr_en;
        mem_addr  = acl_addr;
        mem_data  = acl_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 2'd0;
    else if (fire) ptr <= inc3(gid);
  end

  // Tag pipe tracks which requester owns the word arriving on mem_q.
  logic [RD_LATENCY-1:0] tv;
  logic [1:0]            tid [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
    end else begin
      tv[0] <= fire && !mem_wr_en;
      for (int i = 1; i < RD_LATENCY; i++)
        tv[i] <= tv[i-1];
    end
    tid[0] <= gid;
    for (int i = 1; i < RD_LATENCY; i++)
      tid[i] <= tid[i-1];
  end

  logic       ret_v;
  logic [1:0] ret_id;

  assign ret_v  = tv[RD_LATENCY-1] && !rst;
  assign ret_id = tid[RD_LATENCY-1];

  assign dma_valid = ret_v && (ret_id == 2'd0);
  assign cpu_valid = ret_v && (ret_id == 2'd1);
  assign acl_valid = ret_v && (ret_id == 2'd2);

  logic [DATA_WIDTH-1:0] dma_hold;
  logic [DATA_WIDTH-1:0] cpu_hold;
  logic [DATA_WIDTH-1:0] acl_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_hold <= '0;
      cpu_hold <= '0;
      acl_hold <= '0;
    end else begin
      if (dma_valid) dma_hold <= mem_q;
      if (cpu_valid) cpu_hold <= mem_q;
      if (acl_valid) acl_hold <= mem_q;
    end
  end

  // Returned word is visible in its valid cycle, then held.
  assign dma_out = dma_valid ? mem_q : dma_hold;
  assign cpu_out = cpu_valid ? mem_q : cpu_hold;
  assign acl_out = acl_valid ? mem_q : acl_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
// Grants are checked per cycle; read returns are popped by a decoupled monitor.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_lock;
  logic        dma_en, cpu_en, acl_en;
  logic        dma_wr_en, cpu_wr_en, acl_wr_en;
  logic [15:0] dma_addr, cpu_addr, acl_addr;
  logic [31:0] dma_data, cpu_data, acl_data;
  logic        dma_gnt, cpu_gnt, acl_gnt;
  logic [31:0] dma_out, cpu_out, acl_out;
  logic        dma_valid, cpu_valid, acl_valid;
  logic        mem_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q;

  mem_port_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .dma_lock(dma_lock),
    .dma_en(dma_en), .cpu_en(cpu_en), .acl_en(acl_en),
    .dma_wr_en(dma_wr_en), .cpu_wr_en(cpu_wr_en), .acl_wr_en(acl_wr_en),
    .dma_addr(dma_addr), .cpu_addr(cpu_addr), .acl_addr(acl_addr),
    .dma_data(dma_data), .cpu_data(cpu_data), .acl_data(acl_data),
    .dma_gnt(dma_gnt), .cpu_gnt(cpu_gnt), .acl_gnt(acl_gnt),
    .dma_out(dma_out), .cpu_out(cpu_out), .acl_out(acl_out),
    .dma_valid(dma_valid), .cpu_valid(cpu_valid), .acl_valid(acl_valid),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [256];
  logic [31:0] qp  [LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h01] <= 32'h00000011;
      mem[8'h02] <= 32'h00000022;
      mem[8'h03] <= 32'h00000033;
    end else if (mem_en && mem_wr_en) begin
      mem[mem_addr[7:0]] <= mem_data;
    end
    qp[0] <= (mem_en && !mem_wr_en) ? mem[mem_addr[7:0]] : 32'h0;
    for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
  end

  assign mem_q = qp[LAT-1];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int vec = 0;
  int bad = 0;

  task automatic monitor();
    exp_t e;
    logic [2:0] vs;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      vs = {acl_valid, cpu_valid, dma_valid};
      if (vs !== 3'b000) begin
        vec++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL rd_ret cyc=%0d unexpected valid=%b", cyc, vs);
        end else begin
          e = sbq.pop_front();
          got = (e.id == 2'd0) ? dma_out :
                (e.id == 2'd1) ? cpu_out : acl_out;
          if (vs !== (3'b001 << e.id) || got !== e.d || cyc != e.due) begin
            bad++;
            $display("FAIL rd_ret cyc=%0d valid=%b data=%h want valid=%b data=%h cyc=%0d",
                     cyc, vs, got, 3'b001 << e.id, e.d, e.due);
          end
        end
      end
    end
  endtask

  task automatic tick(input logic [2:0] eg, input logic ew,
                      input logic [15:0] ea, input logic [31:0] ed,
                      input logic xp);
    @(negedge clk);
    vec++;
    if ({acl_gnt, cpu_gnt, dma_gnt} !== eg) begin
      bad++;
      $display("FAIL gnt cyc=%0d got %b want %b",
               cyc, {acl_gnt, cpu_gnt, dma_gnt}, eg);
    end
    vec++;
    if (mem_en !== (eg != 3'b000)) begin
      bad++;
      $display("FAIL mem_en cyc=%0d got %b want %b", cyc, mem_en, eg != 3'b000);
    end
    if (eg != 3'b000) begin
      vec++;
      if (mem_addr !== ea || mem_wr_en !== ew) begin
        bad++;
        $display("FAIL mem_cmd cyc=%0d got a=%h w=%b want a=%h w=%b",
                 cyc, mem_addr, mem_wr_en, ea, ew);
      end
      if (ew) begin
        vec++;
        if (mem_data !== ed) begin
          bad++;
          $display("FAIL mem_data cyc=%0d got %h want %h", cyc, mem_data, ed);
        end
      end else if (xp) begin
        sbq.push_back('{id: (eg[0] ? 2'd0 : eg[1] ? 2'd1 : 2'd2),
                        d: ed, due: cyc + LAT});
      end
    end else begin
      vec++;
      if (mem_wr_en !== 1'b0 || mem_addr !== 16'h0 || mem_data !== 32'h0) begin
        bad++;
        $display("FAIL mem_idle cyc=%0d got w=%b a=%h d=%h want 0",
                 cyc, mem_wr_en, mem_addr, mem_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] ed,
                         input logic [31:0] ec, input logic [31:0] ea);
    vec++;
    if (dma_out !== ed || cpu_out !== ec || acl_out !== ea) begin
      bad++;
      $display("FAIL %s got %h/%h/%h want %h/%h/%h",
               nm, dma_out, cpu_out, acl_out, ed, ec, ea);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(3'b000, 1'b0, 16'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dma_lock = 1'b0;
    dma_en = 0; cpu_en = 0; acl_en = 0;
    dma_wr_en = 0; cpu_wr_en = 0; acl_wr_en = 0;
    dma_addr = 16'h1; cpu_addr = 16'h2; acl_addr = 16'h3;
    dma_data = 32'h0; cpu_data = 32'h0; acl_data = 32'h0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    dma_en = 1; cpu_en = 1; acl_en = 1;
    tick(3'b000, 1'b0, 16'h0, 32'h0, 1'b0);
    chk_out("reset_out", 32'h0, 32'h0, 32'h0);
    vec++;
    if ({dma_valid, cpu_valid, acl_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valid got %b want 000", {dma_valid, cpu_valid, acl_valid});
    end
    rst = 1'b0;
    dma_en = 0; cpu_en = 0; acl_en = 0;
    idle(1);

    // Single CPU read.
    cpu_en = 1; cpu_addr = 16'h0010;
    tick(3'b010, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b1);
    cpu_en = 0;
    idle(LAT + 1);
    chk_out("cpu_hold", 32'h0, 32'hDEADBEEF, 32'h0);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_out("reset_clears_out", 32'h0, 32'h0, 32'h0);

    // Round robin with back-to-back pipelined reads.
    dma_en = 1; cpu_en = 1; acl_en = 1;
    dma_addr = 16'h1; cpu_addr = 16'h2; acl_addr = 16'h3;
    for (int r = 0; r < 2; r++) begin
      tick(3'b001, 1'b0, 16'h1, 32'h11, 1'b1);
      tick(3'b010, 1'b0, 16'h2, 32'h22, 1'b1);
      tick(3'b100, 1'b0, 16'h3, 32'h33, 1'b1);
    end
    dma_en = 0; cpu_en = 0; acl_en = 0;
    idle(LAT);
    chk_out("rr_out", 32'h11, 32'h22, 32'h33);

    // DMA lock: all request, only DMA wins; then rotation resumes at CPU.
    dma_lock = 1;
    dma_en = 1; cpu_en = 1; acl_en = 1;
    dma_wr_en = 1; cpu_wr_en = 1; acl_wr_en = 1;
    dma_addr = 16'h0080; cpu_addr = 16'h0090; acl_addr = 16'h00A0;
    dma_data = 32'hA5A50001; cpu_data = 32'h5A5A0002; acl_data = 32'h3C3C0003;
    repeat (4) tick(3'b001, 1'b1, 16'h0080, 32'hA5A50001, 1'b0);
    dma_lock = 0;
    tick(3'b010, 1'b1, 16'h0090, 32'h5A5A0002, 1'b0);
    tick(3'b100, 1'b1, 16'h00A0, 32'h3C3C0003, 1'b0);
    tick(3'b001, 1'b1, 16'h0080, 32'hA5A50001, 1'b0);

    // Lock with DMA idle blocks everyone.
    dma_lock = 1; dma_en = 0;
    tick(3'b000, 1'b0, 16'h0, 32'h0, 1'b0);
    dma_lock = 0;
    cpu_en = 0; acl_en = 0;
    dma_wr_en = 0; cpu_wr_en = 0;

    // ACL write then read-back.
    acl_en = 1; acl_wr_en = 1; acl_addr = 16'h0040; acl_data = 32'hCAFEF00D;
    tick(3'b100, 1'b1, 16'h0040, 32'hCAFEF00D, 1'b0);
    acl_wr_en = 0; acl_data = 32'h0;
    tick(3'b100, 1'b0, 16'h0040, 32'hCAFEF00D, 1'b1);
    acl_en = 0;
    idle(LAT);
    chk_out("wr_rd_out", 32'h11, 32'h22, 32'hCAFEF00D);

    // Reset while a CPU read is in flight.
    cpu_en = 1; cpu_addr = 16'h2;
    tick(3'b010, 1'b0, 16'h2, 32'h22, 1'b0);
    cpu_en = 0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    dma_en = 1; cpu_en = 1;
    dma_wr_en = 1; cpu_wr_en = 1;
    tick(3'b001, 1'b1, 16'h0080, 32'hA5A50001, 1'b0);
    dma_en = 0; cpu_en = 0;
    dma_wr_en = 0; cpu_wr_en = 0;
    idle(LAT + 2);
    chk_out("post_reset_out", 32'h0, 32'h0, 32'h0);

    vec++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_reads got %0d outstanding want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
